// File: rtl/sha3_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words for the SHA-3 core and
// marks the final word with its valid byte count (an empty word if the message ends on a word boundary).
module sha3_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] h_in,
    output logic        h_in_ready,
    output logic        h_is_last,
    output logic [1:0]  h_byte_num,
    input  logic        h_buffer_full,
    output logic        msg_done,
    output logic [15:0] msg_bytes
);

    // Handshakes: a byte moves when s_valid && s_ready; a word moves when
    // h_in_ready && !h_buffer_full. Neither side may retract a presented item.
    typedef enum logic [1:0] {
        COLLECT    = 2'd0,
        SEND       = 2'd1,
        SEND_EMPTY = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  lane_cnt;
    logic [31:0] word_q;
    logic        last_q;
    logic        pend_empty_q;
    logic [15:0] byte_cnt_q;
    logic        byte_xfer;
    logic        word_xfer;

    assign h_in      = word_q;
    assign msg_bytes = byte_cnt_q;

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        h_in_ready = 1'b0;
        h_is_last  = 1'b0;
        h_byte_num = 2'd0;
        msg_done   = 1'b0;
        byte_xfer  = 1'b0;
        word_xfer  = 1'b0;
        case (state)
            COLLECT: begin
                s_ready   = rst_n;
                byte_xfer = s_valid && rst_n;
                if (byte_xfer && (s_last || lane_cnt == 2'd3))
                    state_next = SEND;
            end
            SEND: begin
                h_in_ready = rst_n;
                h_is_last  = rst_n && last_q;
                // In SEND lane_cnt already equals the number of bytes in a short final word.
                h_byte_num = (rst_n && last_q) ? lane_cnt : 2'd0;
                word_xfer  = rst_n && !h_buffer_full;
                if (word_xfer) begin
                    if (last_q)
                        state_next = DONE;
                    else if (pend_empty_q)
                        state_next = SEND_EMPTY;
                    else
                        state_next = COLLECT;
                end
            end
            SEND_EMPTY: begin
                h_in_ready = rst_n;
                h_is_last  = rst_n;
                word_xfer  = rst_n && !h_buffer_full;
                if (word_xfer)
                    state_next = DONE;
            end
            DONE: begin
                msg_done = rst_n;
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= COLLECT;
            lane_cnt     <= 2'd0;
            word_q       <= 32'd0;
            last_q       <= 1'b0;
            pend_empty_q <= 1'b0;
            byte_cnt_q   <= 16'd0;
        end else begin
            state <= state_next;
            if (byte_xfer) begin
                case (lane_cnt)
                    2'd0:    word_q[31:24] <= s_data;
                    2'd1:    word_q[23:16] <= s_data;
                    2'd2:    word_q[15:8]  <= s_data;
                    default: word_q[7:0]   <= s_data;
                endcase
                lane_cnt <= lane_cnt + 2'd1;
                // A final byte that fills the word still needs an empty terminator word.
                if (s_last) begin
                    if (lane_cnt == 2'd3)
                        pend_empty_q <= 1'b1;
                    else
                        last_q <= 1'b1;
                end
                if (byte_cnt_q != 16'hFFFF)
                    byte_cnt_q <= byte_cnt_q + 16'd1;
            end
            if (word_xfer && state == SEND) begin
                lane_cnt <= 2'd0;
                word_q   <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Randomized and directed bench for sha3_byte_packer: a message-level model
// predicts every word the hash core must see, checked on each negative edge.
module tb_sha3_byte_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] h_in;
    logic        h_in_ready;
    logic        h_is_last;
    logic [1:0]  h_byte_num;
    logic        h_buffer_full = 1'b0;
    logic        msg_done;
    logic [15:0] msg_bytes;

    sha3_byte_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .h_in          (h_in),
        .h_in_ready    (h_in_ready),
        .h_is_last     (h_is_last),
        .h_byte_num    (h_byte_num),
        .h_buffer_full (h_buffer_full),
        .msg_done      (msg_done),
        .msg_bytes     (msg_bytes)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Word entries are {h_in, h_is_last, h_byte_num}.
    logic [34:0] exp_q[$];
    logic [34:0] log_q[$];
    logic [7:0]  buf_q[$];
    int          exp_bytes = 0;
    bit          model_done = 1'b0;
    bit          expect_ready = 1'b0;
    int          full_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] pack_word(input bit last, input int n);
        logic [31:0] word;
        logic [1:0]  nb;
        word = 32'd0;
        for (int i = 0; i < n; i++)
            word[31-8*i -: 8] = buf_q[i];
        nb = n[1:0];
        return {word, last, nb};
    endfunction

    task automatic model_accept(input logic [7:0] d, input bit l);
        if (exp_bytes < 65535) exp_bytes++;
        buf_q.push_back(d);
        if (buf_q.size() == 4) begin
            exp_q.push_back(pack_word(1'b0, 4));
            buf_q.delete();
            expect_ready = 1'b1;
        end
        if (l) begin
            exp_q.push_back(pack_word(1'b1, buf_q.size()));
            buf_q.delete();
            expect_ready = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l, input int max_gap);
        bit acc;
        acc = 1'b0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        if (acc) model_accept(d, l);
        else chk("send_timeout", 64'(acc), 64'd1);
        idle($urandom_range(0, max_gap));
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        idle(2);
        exp_q.delete();
        log_q.delete();
        buf_q.delete();
        exp_bytes    = 0;
        model_done   = 1'b0;
        expect_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = msg_done;
        end
        @(posedge clk);
        #1;
        chk("done_timeout", 64'(ok), 64'd1);
    endtask

    // Per-cycle compare against the model.
    logic [31:0] prev_h;
    logic        prev_last;
    logic [1:0]  prev_bn;
    bit          prev_stall = 1'b0;

    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_h_in_ready", 64'(h_in_ready), 64'd0);
                chk("rst_s_ready", 64'(s_ready), 64'd0);
                chk("rst_msg_done", 64'(msg_done), 64'd0);
                prev_stall = 1'b0;
            end else begin
                if (!h_in_ready) chk("last_without_ready", 64'(h_is_last), 64'd0);
                if (!h_is_last) chk("byte_num_without_last", 64'(h_byte_num), 64'd0);
                if (h_in_ready) chk("s_ready_while_sending", 64'(s_ready), 64'd0);
                chk("msg_bytes", 64'(msg_bytes), 64'(exp_bytes));
                chk("msg_done", 64'(msg_done), 64'(model_done));
                if (msg_done) begin
                    chk("done_s_ready", 64'(s_ready), 64'd0);
                    chk("done_h_in_ready", 64'(h_in_ready), 64'd0);
                end
                if (expect_ready) begin
                    chk("word_latency", 64'(h_in_ready), 64'd1);
                    expect_ready = 1'b0;
                end
                if (prev_stall) begin
                    chk("stall_h_in", 64'(h_in), 64'(prev_h));
                    chk("stall_last", 64'(h_is_last), 64'(prev_last));
                    chk("stall_byte_num", 64'(h_byte_num), 64'(prev_bn));
                end
                if (h_in_ready && !h_buffer_full) begin
                    log_q.push_back({h_in, h_is_last, h_byte_num});
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {h_in, h_is_last, h_byte_num}, 64'd0);
                        chk("unexpected_word_count", 64'd1, 64'(exp_q.size()));
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", {h_in, h_is_last, h_byte_num}, 64'(e));
                        if (e[2]) model_done = 1'b1;
                    end
                end
                prev_stall = h_in_ready && h_buffer_full;
                prev_h     = h_in;
                prev_last  = h_is_last;
                prev_bn    = h_byte_num;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (full_mode)
                0:       h_buffer_full = 1'b0;
                1:       h_buffer_full = ($urandom_range(0, 3) == 0);
                default: h_buffer_full = 1'b1;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        idle(1);
        do_reset();
        #1;
        chk("reset_s_ready", 64'(s_ready), 64'd1);
        chk("reset_h_in_ready", 64'(h_in_ready), 64'd0);
        chk("reset_msg_done", 64'(msg_done), 64'd0);
        chk("reset_msg_bytes", 64'(msg_bytes), 64'd0);
        chk("reset_h_in", 64'(h_in), 64'd0);
        idle(1);

        // Three-byte message ending mid-word.
        send_byte(8'h61, 1'b0, 1);
        send_byte(8'h62, 1'b0, 1);
        send_byte(8'h63, 1'b1, 1);
        wait_done();
        chk("abc_words", 64'(log_q.size()), 64'd1);
        chk("abc_word0", 64'(log_q[0]), 64'({32'h61626300, 1'b1, 2'd3}));
        chk("abc_msg_bytes", 64'(msg_bytes), 64'd3);
        chk("abc_msg_done", 64'(msg_done), 64'd1);

        // Bytes presented in DONE are ignored.
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_last  = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("done_ignore_s_ready", 64'(s_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        idle(2);
        chk("done_ignore_bytes", 64'(msg_bytes), 64'd3);
        chk("done_ignore_words", 64'(log_q.size()), 64'd1);

        // Message ending exactly on a word boundary.
        do_reset();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 4, 0);
        wait_done();
        chk("w4_words", 64'(log_q.size()), 64'd2);
        chk("w4_word0", 64'(log_q[0]), 64'({32'h01020304, 1'b0, 2'd0}));
        chk("w4_word1", 64'(log_q[1]), 64'({32'h00000000, 1'b1, 2'd0}));

        // Nine-byte message.
        do_reset();
        for (int i = 0; i <= 8; i++) send_byte(8'(i), i == 8, 2);
        wait_done();
        chk("b9_words", 64'(log_q.size()), 64'd3);
        chk("b9_word0", 64'(log_q[0]), 64'({32'h00010203, 1'b0, 2'd0}));
        chk("b9_word1", 64'(log_q[1]), 64'({32'h04050607, 1'b0, 2'd0}));
        chk("b9_word2", 64'(log_q[2]), 64'({32'h08000000, 1'b1, 2'd1}));
        chk("b9_msg_bytes", 64'(msg_bytes), 64'd9);

        // Hash core stalls for ten cycles while a word waits in SEND.
        do_reset();
        full_mode = 2;
        h_buffer_full = 1'b1;
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h44, 1'b0, 0);
        s_valid = 1'b1;
        s_data  = 8'h99;
        repeat (10) begin
            @(negedge clk);
            chk("stall_s_ready", 64'(s_ready), 64'd0);
            chk("stall_ready", 64'(h_in_ready), 64'd1);
            chk("stall_word", 64'(h_in), 64'h11223344);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("stall_no_transfer", 64'(log_q.size()), 64'd0);
        full_mode = 0;
        h_buffer_full = 1'b0;
        idle(4);
        chk("stall_one_transfer", 64'(log_q.size()), 64'd1);
        chk("stall_word0", 64'(log_q[0]), 64'({32'h11223344, 1'b0, 2'd0}));
        send_byte(8'h55, 1'b1, 0);
        wait_done();
        chk("stall_word1", 64'(log_q[1]), 64'({32'h55000000, 1'b1, 2'd1}));

        // Reset mid-word discards the partial word.
        do_reset();
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        do_reset();
        send_byte(8'hAA, 1'b0, 1);
        send_byte(8'hBB, 1'b0, 1);
        send_byte(8'hCC, 1'b0, 1);
        send_byte(8'hDD, 1'b1, 1);
        wait_done();
        chk("rst_mid_words", 64'(log_q.size()), 64'd2);
        chk("rst_mid_word0", 64'(log_q[0]), 64'({32'hAABBCCDD, 1'b0, 2'd0}));
        chk("rst_mid_word1", 64'(log_q[1]), 64'({32'h00000000, 1'b1, 2'd0}));

        // Random messages with random back-pressure and gaps.
        full_mode = 1;
        for (int m = 0; m < 12; m++) begin
            do_reset();
            if (m == 5) begin
                len = $urandom_range(1, 6);
                for (int j = 0; j < len; j++) send_byte(8'($urandom), 1'b0, 1);
                do_reset();
            end
            len = $urandom_range(1, 14);
            for (int j = 0; j < len; j++)
                send_byte(8'($urandom_range(0, 255)), j == len - 1, 2);
            wait_done();
            chk("rand_queue_drained", 64'(exp_q.size()), 64'd0);
            chk("rand_msg_bytes", 64'(msg_bytes), 64'(len));
        end
        full_mode = 0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha3_byte_packer.md
SHA3_BYTE_PACKER -- requirements
Module: sha3_byte_packer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-002 Port `clk`: input, 1 bit, the system clock.
REQ-003 Port `rst_n`: input, 1 bit, synchronous active-low reset.
REQ-004 Port `s_data`: input, 8 bits, message byte from the UART receiver.
REQ-005 Port `s_valid`: input, 1 bit, `s_data` is valid.
REQ-006 Port `s_last`: input, 1 bit, the current byte is the final message byte; it is qualified by `s_valid`.
REQ-007 Port `s_ready`: output, 1 bit, the packer accepts a byte this cycle.
REQ-008 Port `h_in`: output, 32 bits, word to the hash core.
REQ-009 Port `h_in_ready`: output, 1 bit, `h_in` is valid.
REQ-010 Port `h_is_last`: output, 1 bit, the word is the final message word.
REQ-011 Port `h_byte_num`: output, 2 bits, the count of valid bytes in the final word; it is meaningful only when `h_is_last`=1.
REQ-012 Port `h_buffer_full`: input, 1 bit, the hash core cannot accept a word this cycle.
REQ-013 Port `msg_done`: output, 1 bit, high once the final word has been transferred.
REQ-014 Port `msg_bytes`: output, 16 bits, count of accepted message bytes; it saturates at 0xFFFF.

Function
REQ-015 Byte transfer SHALL occur on any cycle where `s_valid`=1 and `s_ready`=1.
REQ-016 Word transfer SHALL occur on any cycle where `h_in_ready`=1 and `h_buffer_full`=0.
REQ-017 The FSM SHALL have the states COLLECT, SEND, SEND_EMPTY and DONE, and SHALL enter COLLECT on reset.
REQ-018 `s_ready` SHALL be 1 only in COLLECT with `rst_n`=1, and 0 in all other states.
REQ-019 In COLLECT, the k-th byte of a word (k=0..3) SHALL be written to `h_in` bits [31-8k:24-8k]; the first byte goes in the MSB lane.
REQ-020 Unfilled byte lanes of `h_in` SHALL read 0.
REQ-021 In COLLECT, when the 4th byte is accepted with `s_last`=0, the FSM SHALL go to SEND with last=0.
REQ-022 In COLLECT, when a byte with `s_last`=1 is accepted as byte 1..3 of a word, the FSM SHALL go to SEND with last=1 and `h_byte_num` equal to the number of bytes in the word (1..3).
REQ-023 In COLLECT, when a byte with `s_last`=1 is accepted as the 4th byte of a word, the FSM SHALL go to SEND with last=0 and SHALL set a pending-empty flag.
REQ-024 In SEND, `h_in_ready` SHALL be 1 and `h_is_last` SHALL equal the stored last flag.
REQ-025 On a word transfer from SEND, the FSM SHALL go to DONE if last=1, to SEND_EMPTY if the pending-empty flag is set, and to COLLECT otherwise.
REQ-026 On every word transfer from SEND, the byte lane counter and the `h_in` register SHALL be cleared.
REQ-027 In SEND_EMPTY, outputs SHALL be `h_in_ready`=1, `h_is_last`=1, `h_byte_num`=0, `h_in`=0.
REQ-028 On a word transfer from SEND_EMPTY, the FSM SHALL go to DONE.
REQ-029 While `h_buffer_full`=1, SEND and SEND_EMPTY SHALL hold with `h_in`, `h_is_last` and `h_byte_num` stable; there is no timeout.
REQ-030 `h_is_last` SHALL be 0 whenever `h_in_ready`=0.
REQ-031 `h_byte_num` SHALL be 0 whenever `h_is_last`=0.
REQ-032 `h_in_ready` SHALL be 0 in COLLECT and in DONE.
REQ-033 DONE SHALL be sticky: `msg_done`=1 and `s_ready`=0 until reset; bytes presented in DONE SHALL be ignored and not counted.
REQ-034 Latency: from acceptance of the byte that completes a word to `h_in_ready`=1 SHALL be exactly 1 cycle; there is no combinational path from `s_valid` to `h_in_ready`.
REQ-035 Sustained throughput SHALL be at most 1 word per 5 cycles.
REQ-036 `msg_bytes` SHALL increment by 1 on each byte transfer, capped at 0xFFFF.
REQ-037 `s_valid` asserted with `s_ready`=0 SHALL have no effect.
REQ-038 `s_last` without `s_valid` SHALL be ignored.

Reset
REQ-039 While `rst_n`=0 at a clock edge, the block SHALL set state=COLLECT, lane counter=0, `h_in`=0, last=0, pending-empty=0, `msg_bytes`=0.
REQ-040 Reset SHALL force `h_in_ready`=0, `h_is_last`=0, `h_byte_num`=0, `msg_done`=0.
REQ-041 `s_ready` SHALL be 0 while `rst_n`=0.
REQ-042 A reset in any state, including mid-word or mid-stall, SHALL discard the partial word with no word transfer; the next word after reset starts in byte lane 0.

Verification
REQ-043 A bench SHALL send bytes 61 62 63 with last on 0x63, and SHALL check one transfer of `h_in`=0x61626300, `h_is_last`=1, `h_byte_num`=3, then `msg_done`=1, `msg_bytes`=3.
REQ-044 A bench SHALL send bytes 01..04 with last on 0x04, and SHALL check a transfer of 0x01020304 with last=0, then a transfer of 0x00000000 with last=1 and byte_num=0, then DONE.
REQ-045 A bench SHALL send 9 bytes 00..08 with last on 0x08, and SHALL check transfers 0x00010203 (last=0), 0x04050607 (last=0), 0x08000000 (last=1, byte_num=1).
REQ-046 A bench SHALL hold `h_buffer_full`=1 for 10 cycles in SEND, and SHALL check that `h_in` is stable, `s_ready`=0 and exactly one transfer occurs after release.
REQ-047 A bench SHALL pulse `rst_n`=0 after 2 bytes, then send AA BB CC DD with last on 0xDD, and SHALL check a first word of 0xAABBCCDD followed by an empty last word.
REQ-048 A bench SHALL present bytes while in DONE, and SHALL check `s_ready`=0, `msg_bytes` unchanged and no further `h_in_ready`.
